// File: rtl/dclk_tx_lanes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dclk_tx_lanes_pkg
//  Description : Shared definitions for the multi-lane serial flit link.
//                Holds the flit field sizes, the transmitter/receiver FSM
//                state encoding and the lane/frame size helpers, so that the
//                matching receiver derives identical framing.
//  Revision    : 1.0  initial release
// ============================================================================
package dclk_tx_lanes_pkg;

    // Flit field sizes; default flit width is their sum.
    localparam int c_hdr_sz  = 2;
    localparam int c_pl_sz   = 4;
    localparam int c_addr_sz = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Bits carried per lane: ceil(flit_w / lanes).
    function automatic int lane_bits(input int flit_w, input int lanes);
        return (flit_w + lanes - 1) / lanes;
    endfunction

    // Start bit + data + optional parity + stop bit.
    function automatic int frame_len(input int lb, input int parity);
        return lb + 2 + ((parity != 0) ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dclk_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dclk_tx_fifo
//  Description : Synchronous FIFO with registered occupancy count.
//                Push while full and pop while empty are ignored.
//                Read data is the current head (valid while !empty).
//  Ports       : clk, reset (async, active-low), push/wdata, pop/rdata,
//                full, empty, count
//  Revision    : 1.0  initial release
// ============================================================================
module dclk_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full is judged on the current count, so a same-cycle pop never
    // makes room for a push.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dclk_tx_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : dclk_tx_lanes
//  Description : Multi-lane serial flit transmitter with input FIFO.
//                Each flit is split over LANES wires; every lane is framed
//                as start(1), data LSB first, optional odd parity, stop(1).
//                channel_busy is synchronised and only consulted in IDLE.
//  Ports       : clk, reset (async, active-low)
//                req/parallel_in  flit push;  tx_busy  FIFO full
//                channel_busy     receiver back-pressure (asynchronous)
//                serial_out       one bit per lane
//                tx_active        frame in flight
//                fifo_count       FIFO occupancy
//                overflow         sticky, push attempted while full
//  Revision    : 1.0  initial release
// ============================================================================
module dclk_tx_lanes
    import dclk_tx_lanes_pkg::*;
#(
    parameter int FLIT_W   = c_hdr_sz + c_pl_sz + c_addr_sz,
    parameter int LANES    = 2,
    parameter int DEPTH    = 4,
    parameter int PARITY   = 0,
    parameter int GAP      = 1,
    parameter int SYNC     = 2,
    parameter int ROUTERID = -1,
    parameter     PORT     = "unknown"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [FLIT_W-1:0]        parallel_in,
    input  logic                     channel_busy,
    output logic                     tx_busy,
    output logic [LANES-1:0]         serial_out,
    output logic                     tx_active,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int LB        = lane_bits(FLIT_W, LANES);
    localparam int PW        = LANES * LB;
    localparam int FRAME_LEN = frame_len(LB, PARITY);
    localparam int CW        = $clog2((FRAME_LEN > 16) ? FRAME_LEN : 16);

    localparam logic [CW-1:0] c_frame_last = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] c_gap_last   = CW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [SYNC-1:0]   r_busy_sync;
    logic              w_busy_sync;
    logic              r_overflow;
    logic              w_load;
    logic              w_full;
    logic              w_empty;
    logic [FLIT_W-1:0] w_head;
    logic [PW-1:0]     w_flit_pad;
    logic              w_unused_dbg;

    // Debug identifiers carry no logic.
    assign w_unused_dbg = ^{32'(ROUTERID), PORT};

    dclk_tx_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req),
        .wdata (parallel_in),
        .pop   (w_load),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign tx_busy = w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy_sync <= '0;
        end else begin
            r_busy_sync <= {r_busy_sync[SYNC-2:0], channel_busy};
        end
    end

    assign w_busy_sync = r_busy_sync[SYNC-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | (req & w_full);
        end
    end

    assign overflow = r_overflow;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && !w_busy_sync) begin
                    w_state_next = ST_SEND;
                    w_load       = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_cnt == '0) begin
                    w_state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One counter serves both SEND (FRAME_LEN-1..0) and GAP (GAP-1..0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= c_frame_last;
        end else if (r_state == ST_SEND && r_cnt == '0) begin
            r_cnt <= c_gap_last;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign tx_active = (r_state == ST_SEND);

    // Zero-extend so trailing lane bits beyond FLIT_W go out as 0.
    assign w_flit_pad = PW'(w_head);

    // ------------------------------------------------------------- lanes
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LB-1:0]        w_data;
        logic [FRAME_LEN-1:0] w_frame;
        logic [FRAME_LEN-1:0] r_shift;

        assign w_data = w_flit_pad[i*LB +: LB];

        // Frame is assembled LSB first: bit 0 is the start bit.
        if (PARITY != 0) begin : g_par
            assign w_frame = {1'b1, ~^w_data, w_data, 1'b1};
        end else begin : g_nopar
            assign w_frame = {1'b1, w_data, 1'b1};
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_shift <= '0;
            end else if (w_load) begin
                r_shift <= w_frame;
            end else if (r_state == ST_SEND) begin
                r_shift <= {1'b0, r_shift[FRAME_LEN-1:1]};
            end
        end

        assign serial_out[i] = r_shift[0] & tx_active;
    end

endmodule
`default_nettype wire

// File: tb/tb_dclk_tx_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dclk_tx_lanes
//  Description : Testbench for dclk_tx_lanes. A transaction-level model
//                predicts FIFO contents, frame start times and flags; frames
//                are queued on a scoreboard and compared bit by bit by a
//                monitor. A second instance covers the padded-lane case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dclk_tx_lanes;

    localparam int FW    = 8;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int PAR   = 1;
    localparam int GAPC  = 1;
    localparam int SYNCC = 2;
    localparam int LB    = (FW + LANES - 1) / LANES;
    localparam int FL    = LB + 2 + PAR;

    logic             clk;
    logic             reset;
    logic             req;
    logic [FW-1:0]    parallel_in;
    logic             channel_busy;
    logic             tx_busy;
    logic [LANES-1:0] serial_out;
    logic             tx_active;
    logic [2:0]       fifo_count;
    logic             overflow;

    logic             req2;
    logic [6:0]       parallel_in2;
    logic             tx_busy2;
    logic [1:0]       serial_out2;
    logic             tx_active2;
    logic [2:0]       fifo_count2;
    logic             overflow2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dclk_tx_lanes #(
        .FLIT_W (FW), .LANES (LANES), .DEPTH (DEPTH), .PARITY (PAR),
        .GAP (GAPC), .SYNC (SYNCC), .ROUTERID (3), .PORT ("east")
    ) dut (
        .clk (clk), .reset (reset), .req (req), .parallel_in (parallel_in),
        .channel_busy (channel_busy), .tx_busy (tx_busy),
        .serial_out (serial_out), .tx_active (tx_active),
        .fifo_count (fifo_count), .overflow (overflow)
    );

    dclk_tx_lanes #(
        .FLIT_W (7), .LANES (2), .DEPTH (4), .PARITY (0), .GAP (1), .SYNC (2)
    ) dut2 (
        .clk (clk), .reset (reset), .req (req2), .parallel_in (parallel_in2),
        .channel_busy (1'b0), .tx_busy (tx_busy2),
        .serial_out (serial_out2), .tx_active (tx_active2),
        .fifo_count (fifo_count2), .overflow (overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected bit k of the frame on a lane, straight from the framing rules.
    function automatic logic frame_bit(input logic [FW-1:0] f, input int lane, input int k);
        int ones;
        int idx;
        if (k == 0 || k == FL - 1) return 1'b1;
        if (PAR != 0 && k == LB + 1) begin
            ones = 0;
            for (int j = 0; j < LB; j++) begin
                idx = lane * LB + j;
                if (idx < FW && f[idx]) ones++;
            end
            return (ones % 2 == 0);
        end
        idx = lane * LB + k - 1;
        return (idx < FW) ? f[idx] : 1'b0;
    endfunction

    // ------------------------------------------------------------- model
    typedef struct {
        logic [FW-1:0] flit;
        int            start;
    } sb_t;

    logic [FW-1:0] m_q[$];
    sb_t           sb[$];
    int            starts[$];
    int            m_next_idle = 0;
    int            m_fs = -100;
    logic          m_ovf = 1'b0;
    logic [SYNCC-1:0] m_hist = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            sb.delete();
            m_next_idle = 0;
            m_fs        = -100;
            m_ovf       = 1'b0;
            m_hist      = '0;
        end else begin
            logic   bs;
            logic   pop;
            logic   push_ok;
            sb_t    e;
            cyc++;
            // Receiver busy is seen SYNC edges after it is driven.
            bs      = m_hist[SYNCC-1];
            pop     = (cyc >= m_next_idle) && (m_q.size() > 0) && !bs;
            push_ok = req && (m_q.size() < DEPTH);
            if (req && m_q.size() >= DEPTH) m_ovf = 1'b1;
            if (pop) begin
                e.flit      = m_q.pop_front();
                e.start     = cyc;
                sb.push_back(e);
                m_fs        = cyc;
                m_next_idle = cyc + FL + GAPC + 1;
            end
            if (push_ok) m_q.push_back(parallel_in);
            m_hist = {m_hist[SYNCC-2:0], channel_busy};
        end
    end

    // ----------------------------------------------------------- monitor
    logic          prev_active = 1'b0;
    logic          collecting  = 1'b0;
    int            mon_k = 0;
    logic [FW-1:0] cur_flit;
    logic [15:0]   got_bits [LANES];

    always @(negedge clk) begin
        if (!reset) begin
            collecting  = 1'b0;
            prev_active = 1'b0;
        end else begin
            logic exp_act;
            sb_t  e;
            exp_act = (cyc >= m_fs) && (cyc < m_fs + FL);
            chk("fifo_count", fifo_count, m_q.size());
            chk("tx_busy", tx_busy, (m_q.size() == DEPTH));
            chk("overflow", overflow, m_ovf);
            chk("tx_active", tx_active, exp_act);
            if (!tx_active) chk("serial_idle", serial_out, 0);
            if (tx_active && !prev_active) begin
                starts.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("frame_start", cyc, e.start);
                    cur_flit   = e.flit;
                    collecting = 1'b1;
                    mon_k      = 0;
                end
            end
            if (collecting) begin
                for (int l = 0; l < LANES; l++) begin
                    got_bits[l][mon_k] = serial_out[l];
                    chk($sformatf("lane%0d_bit%0d", l, mon_k), serial_out[l],
                        frame_bit(cur_flit, l, mon_k));
                end
                mon_k++;
                if (mon_k == FL) collecting = 1'b0;
            end
            prev_active = tx_active;
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic push1(input logic [FW-1:0] d);
        @(posedge clk); #2 req = 1'b1; parallel_in = d;
        @(posedge clk); #2 req = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int bound);
        int t = 0;
        while (starts.size() < n && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("wait_starts", (starts.size() >= n), 1);
    endtask

    initial begin
        int n0;
        int push_e;
        int t;
        logic [5:0] v0;
        logic [5:0] v1;

        reset = 1'b0; req = 1'b0; parallel_in = '0; channel_busy = 1'b0;
        req2 = 1'b0; parallel_in2 = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_active", tx_active, 0);

        // Padded lane, no parity, 6-bit frames.
        @(posedge clk); #2 req2 = 1'b1; parallel_in2 = 7'h7F;
        @(posedge clk); #2 req2 = 1'b0;
        t = 0;
        while (!tx_active2 && t < 10) begin @(negedge clk); t++; end
        chk("p7_started", tx_active2, 1);
        for (int k = 0; k < 6; k++) begin
            v0[k] = serial_out2[0];
            v1[k] = serial_out2[1];
            @(negedge clk);
        end
        chk("p7_lane0", v0, 6'b111111);
        chk("p7_lane1", v1, 6'b101111);
        chk("p7_len", tx_active2, 0);

        // Single flit: latency and framed patterns.
        n0 = starts.size();
        push1(8'hA5);
        push_e = cyc;
        wait_starts(n0 + 1, 10);
        chk("latency", starts[$] - push_e, 1);
        repeat (FL + 1) @(negedge clk);
        chk("a5_lane0", got_bits[0][6:0], 7'b1101011);
        chk("a5_lane1", got_bits[1][6:0], 7'b1110101);
        repeat (4) @(negedge clk);

        // Fill while the receiver is busy.
        @(posedge clk); #2 channel_busy = 1'b1;
        repeat (4) @(posedge clk);
        n0 = starts.size();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2 req = 1'b1; parallel_in = 8'(8'h10 + i);
        end
        @(posedge clk); #2 req = 1'b0;
        @(negedge clk);
        chk("full_count", fifo_count, 4);
        chk("full_busy", tx_busy, 1);
        chk("full_ovf", overflow, 1);
        chk("full_serial", serial_out, 0);

        // Release: four frames nine cycles apart.
        @(posedge clk); #2 channel_busy = 1'b0;
        wait_starts(n0 + 4, 80);
        for (int i = 1; i < 4; i++) chk("spacing", starts[n0 + i] - starts[n0 + i - 1], 9);
        chk("drained_count", fifo_count, 0);
        repeat (12) @(negedge clk);

        // Busy raised mid-frame: frame completes, next one held.
        n0 = starts.size();
        push1(8'h3C);
        push1(8'hC3);
        wait_starts(n0 + 1, 10);
        @(posedge clk); #2 channel_busy = 1'b1;
        repeat (30) @(negedge clk);
        chk("held_starts", starts.size(), n0 + 1);
        chk("held_count", fifo_count, 1);
        @(posedge clk); #2 channel_busy = 1'b0;
        wait_starts(n0 + 2, 30);
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-frame.
        n0 = starts.size();
        push1(8'h96);
        push1(8'h5A);
        wait_starts(n0 + 1, 10);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_serial", serial_out, 0);
        chk("arst_active", tx_active, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        n0 = starts.size();
        push1(8'hE7);
        wait_starts(n0 + 1, 10);
        repeat (12) @(negedge clk);

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2
            req         = ($urandom_range(0, 2) == 0);
            parallel_in = 8'($urandom);
            if ($urandom_range(0, 24) == 0) channel_busy = !channel_busy;
        end
        @(posedge clk); #2 req = 1'b0; channel_busy = 1'b0;
        t = 0;
        while ((m_q.size() != 0 || sb.size() != 0 || collecting) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain", (m_q.size() == 0 && sb.size() == 0 && !collecting), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
